// File: rtl/fsk_tx_sequencer_if.sv
// Byte handshake between a frame source and the FSK transmit sequencer.
// The master drives the data, valid and abort signals. The slave returns tx_ready.
interface fsk_tx_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_abort;

  modport master (output tx_data, output tx_valid, output tx_abort, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_abort, output tx_ready);
endinterface

// File: rtl/fsk_tx_sequencer.sv
// FSK frame sequencer. A frame is an alternating preamble, then start, 8 data bits (LSB first) and stop.
// Each bit gets a modulator reload count. Define FSK_TX_PARITY_EN to insert an even-parity bit before stop.
module fsk_tx_sequencer #(
  parameter int         BIT_CYCLES    = 500,
  parameter int         PREAMBLE_BITS = 16,
  parameter logic [7:0] ARR_MARK      = 8'd99,
  parameter logic [7:0] ARR_SPACE     = 8'd124
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fsk_tx_sequencer_if.slave      tx,
  output logic                   mod_en,
  output logic                   mod_bit,
  output logic [7:0]             mod_arr,
  output logic                   busy
);

  localparam int CYC_W   = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_MAX = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
  localparam int IDX_W   = $clog2(IDX_MAX);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_BITS - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_START,
    S_DATA,
`ifdef FSK_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [7:0]       shift_reg;
  logic             ready_en_reg;
`ifdef FSK_TX_PARITY_EN
  logic             parity_reg;
`endif

  logic bit_end;
  logic accept;

  assign bit_end = (cyc_cnt == CYC_LAST);

  // Ready stays low through reset and until the first clock after release.
  assign tx.tx_ready = ready_en_reg && !tx.tx_abort &&
                       ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign accept = tx.tx_valid && tx.tx_ready;

  function automatic logic [7:0] arr_for(input logic b);
    return b ? ARR_MARK : ARR_SPACE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cyc_cnt      <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      ready_en_reg <= 1'b0;
`ifdef FSK_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
      mod_en       <= 1'b0;
      mod_bit      <= 1'b0;
      mod_arr      <= ARR_SPACE;
      busy         <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (tx.tx_abort) begin
        state   <= S_IDLE;
        cyc_cnt <= '0;
        bit_idx <= '0;
        mod_en  <= 1'b0;
        mod_bit <= 1'b0;
        mod_arr <= ARR_SPACE;
        busy    <= 1'b0;
      end else if (state == S_IDLE) begin
        if (accept) begin
          shift_reg <= tx.tx_data;
`ifdef FSK_TX_PARITY_EN
          parity_reg <= ^tx.tx_data;
`endif
          state   <= S_PREAMBLE;
          cyc_cnt <= '0;
          bit_idx <= '0;
          mod_en  <= 1'b1;
          busy    <= 1'b1;
          mod_bit <= 1'b1;
          mod_arr <= arr_for(1'b1);
        end
      end else if (!bit_end) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end else begin
        cyc_cnt <= '0;
        case (state)
          S_PREAMBLE: begin
            if (bit_idx == PRE_LAST) begin
              state   <= S_START;
              bit_idx <= '0;
              mod_bit <= 1'b0;
              mod_arr <= arr_for(1'b0);
            end else begin
              bit_idx <= bit_idx + 1'b1;
              mod_bit <= ~mod_bit;
              mod_arr <= arr_for(~mod_bit);
            end
          end
          S_START: begin
            state   <= S_DATA;
            bit_idx <= '0;
            mod_bit <= shift_reg[0];
            mod_arr <= arr_for(shift_reg[0]);
          end
          S_DATA: begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
`ifdef FSK_TX_PARITY_EN
              state   <= S_PARITY;
              mod_bit <= parity_reg;
              mod_arr <= arr_for(parity_reg);
`else
              state   <= S_STOP;
              mod_bit <= 1'b1;
              mod_arr <= arr_for(1'b1);
`endif
            end else begin
              // Shift so the next data bit is always taken from bit 1.
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              mod_bit   <= shift_reg[1];
              mod_arr   <= arr_for(shift_reg[1]);
            end
          end
`ifdef FSK_TX_PARITY_EN
          S_PARITY: begin
            state   <= S_STOP;
            mod_bit <= 1'b1;
            mod_arr <= arr_for(1'b1);
          end
`endif
          S_STOP: begin
            if (accept) begin
              // Back-to-back byte: skip preamble and keep the modulator running.
              shift_reg <= tx.tx_data;
`ifdef FSK_TX_PARITY_EN
              parity_reg <= ^tx.tx_data;
`endif
              state   <= S_START;
              bit_idx <= '0;
              mod_bit <= 1'b0;
              mod_arr <= arr_for(1'b0);
            end else begin
              state   <= S_IDLE;
              bit_idx <= '0;
              mod_en  <= 1'b0;
              mod_bit <= 1'b0;
              mod_arr <= ARR_SPACE;
              busy    <= 1'b0;
            end
          end
          default: begin
            state   <= S_IDLE;
            bit_idx <= '0;
            mod_en  <= 1'b0;
            mod_bit <= 1'b0;
            mod_arr <= ARR_SPACE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
